// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the Bridge data bus.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_lock;
    logic [AW-1:0] m0_addr;
    logic          m0_wen;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic          m1_wen;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] Bus_addr;
    logic          Bus_wen;
    logic [DW-1:0] Bus_wdata;
    logic [DW-1:0] Bus_rdata;
    logic [1:0]    owner;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_wen, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_wen, m1_wdata,
        input  Bus_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output Bus_addr, Bus_wen, Bus_wdata, owner
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_wen, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_wen, m1_wdata,
        output Bus_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  Bus_addr, Bus_wen, Bus_wdata, owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the Bridge data bus: registered grant, round-robin tie-break,
// lock with a bounded hold, and read data returned one cycle after the transfer.
module bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    bus_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [1:0]         req, lock, wen;
    logic [1:0][AW-1:0] addr;
    logic [1:0][DW-1:0] wdata;

    assign req   = {bus.m1_req,   bus.m0_req};
    assign lock  = {bus.m1_lock,  bus.m0_lock};
    assign wen   = {bus.m1_wen,   bus.m0_wen};
    assign addr  = {bus.m1_addr,  bus.m0_addr};
    assign wdata = {bus.m1_wdata, bus.m0_wdata};

    logic [1:0]         state_q, state_d;
    logic               prio_q, prio_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [1:0]         rvalid_q, rvalid_d;
    logic [1:0][DW-1:0] rdata_q, rdata_d;

    logic own_vld, cur, oth, rd_xfer;

    // The unused 2'b11 encoding falls through to IDLE behaviour.
    assign own_vld = (state_q == OWN0) || (state_q == OWN1);
    assign cur     = (state_q == OWN1);
    assign oth     = ~cur;
    assign rd_xfer = own_vld && req[cur] && !wen[cur];

    function automatic logic [1:0] own_st(input logic m);
        return m ? OWN1 : OWN0;
    endfunction

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        hold_cnt_d = '0;
        if (!own_vld) begin
            if (req[0] && req[1]) state_d = own_st(prio_q);
            else if (req[0])      state_d = OWN0;
            else if (req[1])      state_d = OWN1;
            else                  state_d = IDLE;
        end else begin
            if (!req[cur]) begin
                state_d = req[oth] ? own_st(oth) : IDLE;
            end else if (req[oth]) begin
                // Locked owner keeps the bus only while under the hold limit.
                if (lock[cur] && (hold_cnt_q < HOLD_LIM)) hold_cnt_d = hold_cnt_q + 8'd1;
                else                                      state_d    = own_st(oth);
            end
            if (state_d != state_q) prio_d = oth;
        end
    end

    always_comb begin
        rvalid_d = '0;
        rdata_d  = rdata_q;
        if (rd_xfer) begin
            rvalid_d[cur] = 1'b1;
            rdata_d[cur]  = bus.Bus_rdata;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            hold_cnt_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.m0_gnt    = (state_q == OWN0);
    assign bus.m1_gnt    = (state_q == OWN1);
    assign bus.m0_rvalid = rvalid_q[0];
    assign bus.m1_rvalid = rvalid_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];
    assign bus.owner     = state_q;

    assign bus.Bus_addr  = own_vld ? addr[cur]  : '0;
    assign bus.Bus_wdata = own_vld ? wdata[cur] : '0;
    assign bus.Bus_wen   = own_vld && req[cur] && wen[cur];
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of ownership, tie-break, hold limit and read return.
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_HOLD = 8;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    bus_arbiter_if #(.AW(AW), .DW(DW)) bif ();

    bus_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .bus     (bif)
    );

    logic          r_req   [2];
    logic          r_lock  [2];
    logic          r_wen   [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_wdata [2];
    logic [DW-1:0] r_rdata;

    assign bif.m0_req    = r_req[0];
    assign bif.m0_lock   = r_lock[0];
    assign bif.m0_wen    = r_wen[0];
    assign bif.m0_addr   = r_addr[0];
    assign bif.m0_wdata  = r_wdata[0];
    assign bif.m1_req    = r_req[1];
    assign bif.m1_lock   = r_lock[1];
    assign bif.m1_wen    = r_wen[1];
    assign bif.m1_addr   = r_addr[1];
    assign bif.m1_wdata  = r_wdata[1];
    assign bif.Bus_rdata = r_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 none), who wins the next tie, and how many
    // contested locked cycles the current owner has already used.
    int            own;
    int            tie;
    int            streak;
    logic          erv [2];
    logic [DW-1:0] erd [2];

    task automatic mdl_reset();
        own = -1; tie = 0; streak = 0;
        erv[0] = 1'b0; erv[1] = 1'b0;
        erd[0] = '0;   erd[1] = '0;
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_lock[i] = 1'b0; r_wen[i] = 1'b0;
            r_addr[i] = '0;  r_wdata[i] = '0;
        end
        r_rdata = '0;
    endtask

    // Called at posedge+1 with inputs already driven; checks this cycle, advances one.
    task automatic step();
        int  o, nxt, nstreak, y;
        bit  have;
        #2;
        have = (own >= 0);
        o    = have ? own : 0;
        chk("m0_gnt",    bif.m0_gnt, own == 0);
        chk("m1_gnt",    bif.m1_gnt, own == 1);
        chk("owner",     bif.owner, have ? own + 1 : 0);
        chk("bus_addr",  bif.Bus_addr,  have ? r_addr[o]  : '0);
        chk("bus_wdata", bif.Bus_wdata, have ? r_wdata[o] : '0);
        chk("bus_wen",   bif.Bus_wen,   have && r_req[o] && r_wen[o]);
        chk("m0_rvalid", bif.m0_rvalid, erv[0]);
        chk("m1_rvalid", bif.m1_rvalid, erv[1]);
        chk("m0_rdata",  bif.m0_rdata,  erd[0]);
        chk("m1_rdata",  bif.m1_rdata,  erd[1]);

        nxt = own; nstreak = 0;
        if (!have) begin
            if (r_req[0] && r_req[1]) nxt = tie;
            else if (r_req[0])        nxt = 0;
            else if (r_req[1])        nxt = 1;
            else                      nxt = -1;
        end else begin
            y = 1 - own;
            if (!r_req[own])     nxt = r_req[y] ? y : -1;
            else if (r_req[y]) begin
                if (r_lock[own] && (streak + 1 < MAX_HOLD)) nstreak = streak + 1;
                else                                        nxt = y;
            end
            if (nxt != own) tie = y;
        end
        erv[0] = 1'b0; erv[1] = 1'b0;
        if (have && r_req[o] && !r_wen[o]) begin
            erv[o] = 1'b1;
            erd[o] = r_rdata;
        end
        @(posedge cpu_clk); #1;
        own = nxt; streak = nstreak;
    endtask

    task automatic do_reset();
        zero_inputs();
        cpu_rst = 1'b0;
        mdl_reset();
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        @(posedge cpu_clk); #1;
    endtask

    // A waiting requester must keep its request stable until granted.
    task automatic rand_inputs();
        for (int i = 0; i < 2; i++) begin
            r_lock[i] = ($urandom_range(0, 9) < 7);
            if (r_req[i] && own != i) continue;
            r_req[i]   = ($urandom_range(0, 9) < 7);
            r_wen[i]   = $urandom_range(0, 1);
            r_addr[i]  = $urandom;
            r_wdata[i] = $urandom;
        end
        r_rdata = $urandom;
    endtask

    initial begin
        int held;
        zero_inputs();
        mdl_reset();
        #1;
        chk("rst_owner",  bif.owner, 0);
        chk("rst_gnt",    {bif.m0_gnt, bif.m1_gnt}, 0);
        chk("rst_rvalid", {bif.m0_rvalid, bif.m1_rvalid}, 0);
        chk("rst_rdata0", bif.m0_rdata, 0);
        chk("rst_bus",    {bif.Bus_wen, bif.Bus_addr, bif.Bus_wdata}, 0);
        do_reset();

        // single read by m0
        r_req[0] = 1'b1; r_addr[0] = 32'h10; r_wen[0] = 1'b0; r_rdata = 32'hDEADBEEF;
        step();
        chk("rd_gnt",  bif.m0_gnt, 1);
        chk("rd_addr", bif.Bus_addr, 32'h10);
        step();
        chk("rd_rvalid", bif.m0_rvalid, 1);
        chk("rd_rdata",  bif.m0_rdata, 32'hDEADBEEF);
        r_req[0] = 1'b0;
        step();
        step();

        // both request without lock: strict alternation
        do_reset();
        r_req[0] = 1'b1; r_req[1] = 1'b1; r_wen[0] = 1'b1; r_wen[1] = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("alt_owner", bif.owner, (k % 2) ? 2 : 1);
            step();
        end

        // m0 locked against a waiting m1: bounded hold, then forced release
        do_reset();
        r_req[0] = 1'b1; r_req[1] = 1'b1; r_lock[0] = 1'b1; r_wen[0] = 1'b1; r_wen[1] = 1'b1;
        step();
        held = 0;
        while (bif.owner == 2'b01 && held < 20) begin
            held++;
            step();
        end
        chk("hold_len", held, MAX_HOLD);
        chk("hold_rel", bif.owner, 2);
        step();
        step();

        // m1 write, then release to IDLE
        do_reset();
        r_req[1] = 1'b1; r_wen[1] = 1'b1; r_wdata[1] = 32'h55; r_addr[1] = 32'h40;
        step();
        chk("wr_wen",    bif.Bus_wen, 1);
        chk("wr_wdata",  bif.Bus_wdata, 32'h55);
        chk("wr_owner",  bif.owner, 2);
        step();
        chk("wr_rvalid", bif.m1_rvalid, 0);
        r_req[1] = 1'b0;
        step();
        chk("wr_idle",   bif.owner, 0);
        chk("wr_wen0",   bif.Bus_wen, 0);

        // asynchronous reset while m1 owns the bus with a read result pending
        do_reset();
        r_req[1] = 1'b1; r_wen[1] = 1'b0; r_rdata = 32'h1234_5678;
        step();
        step();
        chk("pre_rst_rv", bif.m1_rvalid, 1);
        #2;
        cpu_rst = 1'b0;
        #1;
        chk("arst_gnt",   bif.m1_gnt, 0);
        chk("arst_rv",    bif.m1_rvalid, 0);
        chk("arst_wen",   bif.Bus_wen, 0);
        chk("arst_owner", bif.owner, 0);
        chk("arst_rdata", bif.m1_rdata, 0);
        do_reset();
        chk("post_rst_owner", bif.owner, 0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter that shares the single Bridge data bus (Bus_addr/Bus_wen/Bus_wdata/Bus_rdata) between the CPU data port (master 0) and a second requester such as a DMA or debug loader (master 1).
- Provides registered grant, a round-robin tie-break, an optional lock for back-to-back ownership, and a hold limit that prevents starvation.
- Read data is captured and returned one cycle after the transfer.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, maximum consecutive transfer cycles a locked owner keeps the bus while the other master requests (range 1..255).

Ports:
- cpu_clk  in  1  system clock, rising edge.
- cpu_rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 requests a transfer this cycle.
- m0_lock  in  1  master 0 asks to keep ownership after this transfer.
- m0_addr  in  AW  master 0 address.
- m0_wen  in  1  master 0 write enable.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 owns the bus this cycle.
- m0_rvalid  out  1  m0_rdata holds a read result (one-cycle pulse).
- m0_rdata  out  DW  captured read data for master 0.
- m1_req, m1_lock, m1_addr, m1_wen, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings for master 1.
- Bus_addr  out  AW  address to Bridge.
- Bus_wen  out  1  write strobe to Bridge.
- Bus_wdata  out  DW  write data to Bridge.
- Bus_rdata  in  DW  combinational read data from Bridge.
- owner  out  2  current state encoding: 00 IDLE, 01 OWN0, 10 OWN1.

Behaviour:
- State register values: IDLE, OWN0, OWN1. Registered round-robin pointer `prio` names the master that wins a tie. Hold counter `hold_cnt` is 8 bits.
- Reset (async, cpu_rst=0):
  - state=IDLE, prio=0, hold_cnt=0.
  - mX_gnt=0, mX_rvalid=0, mX_rdata=0.
  - Bus outputs are 0.
  - Any pending read result is discarded.
  - The first edge after release behaves as a normal IDLE cycle.
- mX_gnt is decoded from state only. Bus outputs are combinational from state:
  - OWNx: Bus_addr=mx_addr, Bus_wdata=mx_wdata, Bus_wen=mx_req & mx_wen.
  - IDLE: Bus_addr=0, Bus_wdata=0, Bus_wen=0.
- A transfer occurs in any OWNx cycle with mx_req=1.
  - Read transfer (mx_wen=0): Bus_rdata is sampled at the end of that cycle. mx_rdata holds it and mx_rvalid=1 for exactly the next cycle. mx_rdata holds its value until the next read.
  - Write transfer: no rvalid pulse.
- Grant latency: a request first seen in IDLE is granted on the next edge, so mX_gnt rises one cycle after mX_req. A master must hold req/addr/wen/wdata until it sees gnt.
- IDLE transitions:
  - Only m0_req → OWN0.
  - Only m1_req → OWN1.
  - Both → OWN[prio].
  - Neither → stay in IDLE.
- OWNx transitions (y = other master):
  - mx_req=0 & my_req=1 → OWNy.
  - mx_req=0 & my_req=0 → IDLE.
  - mx_req=1 & my_req=0 → stay.
  - mx_req=1 & my_req=1 & mx_lock=0 → OWNy (direct switch, no IDLE bubble).
  - mx_req=1 & my_req=1 & mx_lock=1 & hold_cnt<MAX_HOLD-1 → stay, hold_cnt+1.
  - mx_req=1 & my_req=1 & mx_lock=1 & hold_cnt=MAX_HOLD-1 → OWNy (forced release).
- hold_cnt clears on every state change and whenever my_req=0. It never wraps.
- prio is set to y whenever the state leaves OWNx, so the last owner loses the next tie.
- Simultaneous release and rvalid: a read on the last owned cycle still produces mx_rvalid in the next cycle, even though mx_gnt has already dropped.

Test Plan:
- Reset with cpu_rst=0 mid-transfer (OWN1, read pending) → all gnt/rvalid/Bus_wen drop to 0 immediately, without waiting for a clock edge; owner=00 after release.
- m0_req=1, m0_wen=0, addr 0x10, Bus_rdata=0xDEADBEEF, m1 idle:
  - m0_gnt=1 at cycle 1.
  - Bus_addr=0x10 at cycle 1.
  - m0_rvalid=1 and m0_rdata=0xDEADBEEF at cycle 2.
- Both request from IDLE after reset, lock=0 → owner sequence OWN0, OWN1, OWN0, OWN1; each gnt pulses in alternate cycles.
- m0 locked with m1 requesting, MAX_HOLD=8 → m0 holds for exactly 8 transfer cycles, then OWN1; with m1 still requesting, the next tie goes to m1.
- m1_req=1, m1_wen=1, wdata 0x55 while owning; m0_req=0 → Bus_wen=1, Bus_wdata=0x55, m1_rvalid stays 0; when m1_req drops, state returns to IDLE the next cycle with Bus_wen=0.
